// File: rtl/my_bullet_ctrl_if.sv
// Bullet controller bus: player/fire/hit inputs toward the controller, bullet state back out.
interface my_bullet_ctrl_if;
  logic       frame_tick;
  logic       fire;
  logic [9:0] player_x;
  logic [9:0] player_y;
  logic       hit;
  logic [9:0] b_x;
  logic [9:0] b_y;
  logic       mybullet_en;
  logic [7:0] shots_fired;

  modport master (
    output frame_tick, fire, player_x, player_y, hit,
    input  b_x, b_y, mybullet_en, shots_fired
  );

  modport slave (
    input  frame_tick, fire, player_x, player_y, hit,
    output b_x, b_y, mybullet_en, shots_fired
  );
endinterface

// File: rtl/my_bullet_ctrl.sv
// Single player bullet: spawns on a fire edge, climbs SPEED px per frame, then a frame-counted cooldown.
module my_bullet_ctrl #(
  parameter int SPEED       = 8,
  parameter int X_OFF       = 18,
  parameter int BULLET_H    = 10,
  parameter int COOL_FRAMES = 16
) (
  input logic clk,
  input logic rst,
  my_bullet_ctrl_if.slave bus
);
  localparam int         CW   = (COOL_FRAMES < 2) ? 1 : $clog2(COOL_FRAMES + 1);
  localparam logic [9:0] SP10 = 10'(SPEED);
  localparam logic [9:0] XO10 = 10'(X_OFF);
  localparam logic [9:0] BH10 = 10'(BULLET_H);
  localparam logic [CW-1:0] COOL = CW'(COOL_FRAMES);
  localparam logic [CW-1:0] ONE  = CW'(1);

  typedef enum logic [1:0] {IDLE, FLIGHT, COOLDOWN} state_t;

  state_t        state_q;
  logic          fire_q;
  logic [9:0]    bx_q, by_q;
  logic          en_q;
  logic [7:0]    shots_q;
  logic [CW-1:0] cnt_q;
  logic          fire_rise;

  assign fire_rise = bus.fire & ~fire_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      // Reset to 1 so a button held through reset does not look like a press.
      fire_q  <= 1'b1;
      bx_q    <= '0;
      by_q    <= '0;
      en_q    <= 1'b0;
      shots_q <= '0;
      cnt_q   <= '0;
    end else begin
      fire_q <= bus.fire;
      case (state_q)
        IDLE: begin
          if (fire_rise) begin
            state_q <= FLIGHT;
            bx_q    <= bus.player_x + XO10;
            by_q    <= (bus.player_y >= BH10) ? bus.player_y - BH10 : '0;
            en_q    <= 1'b1;
            shots_q <= shots_q + 8'd1;
          end
        end
        FLIGHT: begin
          if (bus.hit || (bus.frame_tick && by_q < SP10)) begin
            state_q <= COOLDOWN;
            en_q    <= 1'b0;
            cnt_q   <= COOL;
          end else if (bus.frame_tick) begin
            by_q <= by_q - SP10;
          end
        end
        COOLDOWN: begin
          // A zero count only happens with COOL_FRAMES = 0: leave without waiting for a tick.
          if (cnt_q == '0) begin
            state_q <= IDLE;
          end else if (bus.frame_tick) begin
            cnt_q <= cnt_q - ONE;
            if (cnt_q == ONE) state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.b_x         = bx_q;
  assign bus.b_y         = by_q;
  assign bus.mybullet_en = en_q;
  assign bus.shots_fired = shots_q;
endmodule

// File: tb/tb_my_bullet_ctrl.sv
// Bench for my_bullet_ctrl: directed literal scenarios, then random traffic against a frame-level model.
module tb_my_bullet_ctrl;
  localparam int SPEED = 8, X_OFF = 18, BULLET_H = 10, COOL_FRAMES = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;

  my_bullet_ctrl_if ifc();

  my_bullet_ctrl #(.SPEED(SPEED), .X_OFF(X_OFF), .BULLET_H(BULLET_H), .COOL_FRAMES(COOL_FRAMES))
    dut (.clk(clk), .rst(rst), .bus(ifc.slave));

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: bullet is "alive" with a position, or waiting out a number of frames, or ready.
  bit   alive, waiting;
  int   mx, my, mshots, frames_left;
  bit   last_fire;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      alive = 0; waiting = 0; mx = 0; my = 0; mshots = 0; frames_left = 0; last_fire = 1;
    end else begin
      bit pressed;
      pressed   = ifc.fire && !last_fire;
      last_fire = ifc.fire;
      if (alive) begin
        if (ifc.hit) begin
          alive = 0; waiting = 1; frames_left = COOL_FRAMES;
        end else if (ifc.frame_tick) begin
          if (my - SPEED < 0) begin
            alive = 0; waiting = 1; frames_left = COOL_FRAMES;
          end else my = my - SPEED;
        end
      end else if (waiting) begin
        if (frames_left == 0) waiting = 0;
        else if (ifc.frame_tick) begin
          frames_left = frames_left - 1;
          if (frames_left == 0) waiting = 0;
        end
      end else if (pressed) begin
        alive  = 1;
        mx     = (int'(ifc.player_x) + X_OFF) % 1024;
        my     = (int'(ifc.player_y) >= BULLET_H) ? int'(ifc.player_y) - BULLET_H : 0;
        mshots = (mshots + 1) % 256;
      end
    end
  end

  always @(negedge clk) begin
    chk("model_en",    int'(ifc.mybullet_en), int'(alive));
    chk("model_bx",    int'(ifc.b_x),         mx);
    chk("model_by",    int'(ifc.b_y),         my);
    chk("model_shots", int'(ifc.shots_fired), mshots);
  end

  task automatic cyc(input logic t, input logic f, input logic h);
    ifc.frame_tick = t; ifc.fire = f; ifc.hit = h;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    ifc.frame_tick = 0; ifc.fire = 0; ifc.hit = 0;
    rst = 0;
    @(posedge clk); #1;
    rst = 1;
  endtask

  initial begin
    ifc.frame_tick = 0; ifc.fire = 0; ifc.hit = 0;
    ifc.player_x = 10'd0; ifc.player_y = 10'd0;
    #1;
    chk("reset_en",    int'(ifc.mybullet_en), 0);
    chk("reset_bx",    int'(ifc.b_x), 0);
    chk("reset_shots", int'(ifc.shots_fired), 0);
    @(posedge clk); #1;
    rst = 1;

    // Spawn position, full flight to the top, then held fire never respawns.
    ifc.player_x = 10'd300; ifc.player_y = 10'd420;
    cyc(0, 0, 0);
    cyc(0, 1, 0);
    chk("spawn_bx",    int'(ifc.b_x), 318);
    chk("spawn_by",    int'(ifc.b_y), 410);
    chk("spawn_en",    int'(ifc.mybullet_en), 1);
    chk("spawn_shots", int'(ifc.shots_fired), 1);
    for (int i = 0; i < 51; i++) cyc(1, 1, 0);
    chk("tick51_by", int'(ifc.b_y), 2);
    chk("tick51_en", int'(ifc.mybullet_en), 1);
    cyc(1, 1, 0);
    chk("tick52_en", int'(ifc.mybullet_en), 0);
    for (int i = 0; i < 16; i++) cyc(1, 1, 0);
    cyc(0, 1, 0);
    chk("held_no_spawn",  int'(ifc.mybullet_en), 0);
    chk("held_shots",     int'(ifc.shots_fired), 1);
    cyc(0, 0, 0);
    cyc(0, 1, 0);
    chk("repress_en",    int'(ifc.mybullet_en), 1);
    chk("repress_shots", int'(ifc.shots_fired), 2);

    // Hit beats a same-cycle tick; cooldown length is exactly COOL_FRAMES ticks.
    do_reset();
    ifc.player_y = 10'd110;
    cyc(0, 0, 0);
    cyc(0, 1, 0);
    chk("hit_spawn_by", int'(ifc.b_y), 100);
    cyc(1, 0, 1);
    chk("hit_en", int'(ifc.mybullet_en), 0);
    chk("hit_by", int'(ifc.b_y), 100);
    for (int i = 0; i < 15; i++) cyc(1, 0, 0);
    cyc(0, 1, 0);
    chk("cool15_no_spawn", int'(ifc.mybullet_en), 0);
    cyc(0, 0, 0);
    cyc(1, 0, 0);
    cyc(0, 1, 0);
    chk("cool16_spawn", int'(ifc.mybullet_en), 1);
    chk("cool16_shots", int'(ifc.shots_fired), 2);

    // Spawn near the top clamps to 0 and dies on the first tick.
    do_reset();
    ifc.player_y = 10'd5;
    cyc(0, 0, 0);
    cyc(0, 1, 0);
    chk("clamp_by", int'(ifc.b_y), 0);
    chk("clamp_en", int'(ifc.mybullet_en), 1);
    cyc(1, 1, 0);
    chk("clamp_die", int'(ifc.mybullet_en), 0);

    // Async reset mid-flight, fire held across release.
    do_reset();
    ifc.player_x = 10'd1020; ifc.player_y = 10'd200;
    cyc(0, 0, 0);
    cyc(0, 1, 0);
    chk("wrap_bx", int'(ifc.b_x), 14);
    #2 rst = 0;
    #1;
    chk("async_en",    int'(ifc.mybullet_en), 0);
    chk("async_bx",    int'(ifc.b_x), 0);
    chk("async_by",    int'(ifc.b_y), 0);
    chk("async_shots", int'(ifc.shots_fired), 0);
    cyc(0, 1, 0);
    rst = 1;
    cyc(0, 1, 0);
    cyc(0, 1, 0);
    chk("rel_no_spawn", int'(ifc.mybullet_en), 0);
    chk("rel_shots",    int'(ifc.shots_fired), 0);

    // Random traffic.
    for (int n = 0; n < 4000; n++) begin
      logic f;
      f = ifc.fire;
      if ($urandom_range(5) == 0) f = ~f;
      if ($urandom_range(15) == 0) ifc.player_x = 10'($urandom_range(1023));
      if ($urandom_range(15) == 0) ifc.player_y = ($urandom_range(3) == 0) ? 10'($urandom_range(12)) : 10'($urandom_range(1023));
      if ($urandom_range(599) == 0) begin
        #2 rst = 0;
        cyc(1'($urandom_range(1)), f, 1'($urandom_range(1)));
        rst = 1;
      end else begin
        cyc(($urandom_range(3) == 0), f, ($urandom_range(19) == 0));
      end
    end

    @(negedge clk); #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
